// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the data RAM arbiter: FSM state encoding and
// requester port indices.
package data_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM command/response bus.
// The slave side is the arbiter; the master side is the surrounding system.
interface data_ram_arbiter_if #(
    parameter int width  = 8,
    parameter int length = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              ind0;
    logic              ind1;
    logic [length-1:0] addr0;
    logic [length-1:0] addr1;
    logic [width-1:0]  wdata0;
    logic [width-1:0]  wdata1;
    logic              ack0;
    logic              ack1;
    logic [width-1:0]  rdata0;
    logic [width-1:0]  rdata1;
    logic              err;
    logic              busy;
    logic [length-1:0] ramAddr;
    logic [width-1:0]  ramWriteData;
    logic              ramWriteEnable;
    logic              ramReadEnable;
    logic              ramIndirect;
    logic              ramDataReady;
    logic [width-1:0]  ramReadData;

    modport slave (
        input  req0, req1, we0, we1, ind0, ind1,
        input  addr0, addr1, wdata0, wdata1,
        input  ramDataReady, ramReadData,
        output ack0, ack1, rdata0, rdata1, err, busy,
        output ramAddr, ramWriteData,
        output ramWriteEnable, ramReadEnable, ramIndirect
    );

    modport master (
        output req0, req1, we0, we1, ind0, ind1,
        output addr0, addr1, wdata0, wdata1,
        output ramDataReady, ramReadData,
        input  ack0, ack1, rdata0, rdata1, err, busy,
        input  ramAddr, ramWriteData,
        input  ramWriteEnable, ramReadEnable, ramIndirect
    );
endinterface

// File: rtl/data_ram_arbiter_rr.sv
// Two-way round-robin grant: on a tie the port not served last wins.
module rr_arbiter2
    import data_ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic any
);
    always_comb begin
        grant = PORT0;
        if (req0 && req1) begin
            grant = (last == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            grant = PORT1;
        end
    end

    assign any = req0 | req1;
endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the load/store path (port 0)
// and the I/O/debug master (port 1), one registered RAM command per grant.
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int width   = 8,
    parameter int length  = 8,
    parameter int timeout = 15
) (
    input logic               clk,
    input logic               clr,
    data_ram_arbiter_if.slave bus
);
    localparam int CW = $clog2(timeout + 1);

    state_e            r_state;
    state_e            w_next;
    logic              r_last;
    logic              r_sel;
    logic              r_we;
    logic [CW-1:0]     r_cnt;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err;
    logic [width-1:0]  r_rdata0;
    logic [width-1:0]  r_rdata1;
    logic [length-1:0] r_ram_addr;
    logic [width-1:0]  r_ram_wdata;
    logic              r_ram_we;
    logic              r_ram_re;
    logic              r_ram_ind;

    logic              w_grant;
    logic              w_any;
    logic              w_load;
    logic              w_capture;
    logic              w_tmo;
    logic              w_done;
    logic              w_inc;
    logic              w_we;
    logic              w_ind;
    logic [length-1:0] w_addr;
    logic [width-1:0]  w_wdata;

    rr_arbiter2 u_arb (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (r_last),
        .grant (w_grant),
        .any   (w_any)
    );

    always_comb begin
        w_we    = bus.we0;
        w_ind   = bus.ind0;
        w_addr  = bus.addr0;
        w_wdata = bus.wdata0;
        if (w_grant == PORT1) begin
            w_we    = bus.we1;
            w_ind   = bus.ind1;
            w_addr  = bus.addr1;
            w_wdata = bus.wdata1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_tmo     = 1'b0;
        w_done    = 1'b0;
        w_inc     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_done = 1'b1;
                    w_next = DONE;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the last allowed cycle still wins.
                if (bus.ramDataReady) begin
                    w_capture = 1'b1;
                    w_done    = 1'b1;
                    w_next    = DONE;
                end else if (r_cnt == CW'(timeout)) begin
                    w_tmo  = 1'b1;
                    w_done = 1'b1;
                    w_next = DONE;
                end else begin
                    w_inc = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_last      <= PORT1;
            r_sel       <= PORT0;
            r_we        <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_ind   <= 1'b0;
        end else begin
            r_ram_we  <= 1'b0;
            r_ram_re  <= 1'b0;
            r_ram_ind <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err     <= 1'b0;
            // Strobes are loaded here so they are high exactly in ISSUE.
            if (w_load) begin
                r_sel       <= w_grant;
                r_we        <= w_we;
                r_ram_addr  <= w_addr;
                r_ram_wdata <= w_wdata;
                r_ram_we    <= w_we;
                r_ram_re    <= ~w_we;
                r_ram_ind   <= ~w_we & w_ind;
            end
            if (w_capture) begin
                if (r_sel == PORT1) begin
                    r_rdata1 <= bus.ramReadData;
                end else begin
                    r_rdata0 <= bus.ramReadData;
                end
            end
            if (w_done) begin
                r_ack0 <= (r_sel == PORT0);
                r_ack1 <= (r_sel == PORT1);
                r_err  <= w_tmo;
                r_last <= r_sel;
            end
        end
    end

    assign bus.ack0           = r_ack0;
    assign bus.ack1           = r_ack1;
    assign bus.err            = r_err;
    assign bus.rdata0         = r_rdata0;
    assign bus.rdata1         = r_rdata1;
    assign bus.busy           = (r_state != IDLE);
    assign bus.ramAddr        = r_ram_addr;
    assign bus.ramWriteData   = r_ram_wdata;
    assign bus.ramWriteEnable = r_ram_we;
    assign bus.ramReadEnable  = r_ram_re;
    assign bus.ramIndirect    = r_ram_ind;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench: directed plan items plus random traffic against a
// transaction-level model of grant order, latency and RAM contents.
module tb_data_ram_arbiter;
    localparam int W   = 8;
    localparam int L   = 8;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    data_ram_arbiter_if #(.width(W), .length(L)) bus ();

    data_ram_arbiter #(
        .width   (W),
        .length  (L),
        .timeout (TMO)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // RAM model: answers a read one cycle after its enable when allowed.
    logic [W-1:0] mem [0:255];
    bit           ram_respond;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= W'(i * 37 + 11);
            bus.ramDataReady <= 1'b0;
            bus.ramReadData  <= '0;
        end else begin
            if (bus.ramWriteEnable) mem[bus.ramAddr] <= bus.ramWriteData;
            bus.ramDataReady <= bus.ramReadEnable && ram_respond;
            if (bus.ramReadEnable)
                bus.ramReadData <= bus.ramIndirect ?
                    mem[mem[bus.ramAddr]] : mem[bus.ramAddr];
        end
    end

    // Reference state
    logic [W-1:0] ref_mem [0:255];
    logic [W-1:0] exp_rd [2];
    bit           m_last;
    bit           c_we [2];
    bit           c_ind [2];
    logic [L-1:0] c_addr [2];
    logic [W-1:0] c_wdata [2];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = W'(i * 37 + 11);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        m_last = 1'b1;
    endtask

    task automatic cmd(input int p, input bit we, input bit ind,
                       input logic [L-1:0] a, input logic [W-1:0] d);
        c_we[p]    = we;
        c_ind[p]   = ind;
        c_addr[p]  = a;
        c_wdata[p] = d;
    endtask

    task automatic drop();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // Holds the selected requests until n acks have been seen. Expected
    // grant order and cycle of each enable/ack come from the arbitration
    // rules: write = 3 cycles, answered read = 4, timed-out read = TMO+4.
    task automatic run(input bit u0, input bit u1, input int n,
                       input bit resp);
        int     s, lat, k, ek, limit, p;
        int     e_port [8];
        int     e_ack [8];
        int     e_en [8];
        bit     e_we [8];
        bit     ml;
        logic [W-1:0] ex;
        ram_respond = resp;
        ml = m_last;
        s = 0;
        for (int i = 0; i < n; i++) begin
            p = (u0 && u1) ? (ml ? 0 : 1) : (u1 ? 1 : 0);
            lat = c_we[p] ? 2 : (resp ? 3 : 2 + TMO + 1);
            e_port[i] = p;
            e_we[i]   = c_we[p];
            e_en[i]   = s + 1;
            e_ack[i]  = s + lat;
            s  = s + lat + 1;
            ml = (p == 1);
        end
        limit = s + 3;
        bus.req0 = u0;  bus.we0 = c_we[0];  bus.ind0 = c_ind[0];
        bus.addr0 = c_addr[0];  bus.wdata0 = c_wdata[0];
        bus.req1 = u1;  bus.we1 = c_we[1];  bus.ind1 = c_ind[1];
        bus.addr1 = c_addr[1];  bus.wdata1 = c_wdata[1];
        k = 0;
        ek = 0;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk("busy_idle", bus.busy, 0);
            if (bus.ramWriteEnable || bus.ramReadEnable) begin
                if (ek < n) begin
                    p = e_port[ek];
                    chk("en_cycle", cyc, e_en[ek]);
                    chk("en_we", bus.ramWriteEnable, e_we[ek]);
                    chk("en_rd", bus.ramReadEnable, !e_we[ek]);
                    chk("ram_addr", bus.ramAddr, c_addr[p]);
                    if (e_we[ek]) chk("ram_wdata", bus.ramWriteData, c_wdata[p]);
                    chk("ram_ind", bus.ramIndirect, !e_we[ek] && c_ind[p]);
                end else begin
                    chk("en_count", ek + 1, n);
                end
                ek++;
            end else if (cyc > 0) begin
                chk("ram_ind_idle", bus.ramIndirect, 0);
            end
            if (bus.ack0 || bus.ack1) begin
                chk("ack_both", bus.ack0 & bus.ack1, 0);
                if (k < n) begin
                    p = e_port[k];
                    chk("ack_cycle", cyc, e_ack[k]);
                    chk("ack_port", bus.ack1, p);
                    if (e_we[k]) begin
                        ref_mem[c_addr[p]] = c_wdata[p];
                        chk("err_wr", bus.err, 0);
                    end else begin
                        if (resp) begin
                            ex = c_ind[p] ? ref_mem[ref_mem[c_addr[p]]]
                                          : ref_mem[c_addr[p]];
                            exp_rd[p] = ex;
                        end
                        chk("err_rd", bus.err, !resp);
                    end
                    chk("rdata0", bus.rdata0, exp_rd[0]);
                    chk("rdata1", bus.rdata1, exp_rd[1]);
                end else begin
                    chk("ack_count", k + 1, n);
                end
                k++;
                if (k == n) drop();
            end
            tick();
        end
        chk("acks_total", k, n);
        chk("en_total", ek, n);
        drop();
        m_last = ml;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_we", bus.ramWriteEnable, 0);
        chk("rst_re", bus.ramReadEnable, 0);
        chk("rst_ind", bus.ramIndirect, 0);
        chk("rst_addr", bus.ramAddr, 0);
        chk("rst_wdata", bus.ramWriteData, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
    endtask

    initial begin
        int acks;
        int sel;
        vectors = 0;
        miscompares = 0;
        ram_respond = 1'b1;
        clr = 1'b1;
        drop();
        cmd(0, 0, 0, '0, '0);
        cmd(1, 0, 0, '0, '0);
        bus.we0 = 0; bus.we1 = 0; bus.ind0 = 0; bus.ind1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs();
        tick();
        clr = 1'b0;

        cmd(0, 1, 0, 8'h10, 8'hA5);
        run(1, 0, 1, 1);
        cmd(1, 0, 0, 8'h10, 8'h00);
        run(0, 1, 1, 1);
        chk("plan_rdata1", bus.rdata1, 8'hA5);
        cmd(1, 0, 1, 8'h10, 8'h00);
        run(0, 1, 1, 1);

        cmd(0, 1, 0, 8'h20, 8'h11);
        cmd(1, 1, 0, 8'h21, 8'h22);
        run(1, 1, 4, 1);

        cmd(0, 0, 0, 8'h10, 8'h00);
        run(1, 0, 1, 0);

        // Reset while a read is stuck in WAIT.
        cmd(0, 0, 0, 8'h30, 8'h00);
        ram_respond = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h30;
        for (int i = 0; i < 4; i++) tick();
        chk("busy_wait", bus.busy, 1);
        clr = 1'b1;
        drop();
        tick();
        clr = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs();
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks++;
        end
        chk("no_ack_after_rst", acks, 0);
        tick();
        cmd(0, 1, 0, 8'h31, 8'h77);
        cmd(1, 1, 0, 8'h32, 8'h88);
        run(1, 1, 2, 1);

        cmd(1, 1, 0, 8'h40, 8'h5A);
        run(0, 1, 2, 1);
        cmd(0, 0, 1, 8'h40, 8'h00);
        run(1, 0, 2, 1);

        for (int it = 0; it < 25; it++) begin
            for (int p = 0; p < 2; p++)
                cmd(p, bit'($urandom % 2), bit'($urandom % 2),
                    L'($urandom), W'($urandom));
            sel = int'($urandom_range(0, 2));
            run(sel != 1, sel != 0, int'($urandom_range(1, 3)),
                ($urandom % 5) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-port data RAM between two requesters: port 0 (processor load/store path) and port 1 (I/O/debug master). Arbitrates round-robin, sequences one RAM command per grant with single-cycle enables, and waits for the RAM's `dataReady` on reads. Returns read data with a one-cycle `ack`, and flags an error if the RAM never answers. Sits between the requesters and the data RAM's `addr`/`writeData`/`writeEnable`/`readEnable`/`indirect` inputs.

## Interface
- `width`, 8, data word width; must match the RAM.
- `length`, 8, address width; must match the RAM.
- `timeout`, 15, maximum WAIT cycles before a read is abandoned; minimum 1.

- `clk` in 1: single clock; all logic on posedge.
- `clr` in 1: synchronous, active-high reset.
- `req0`/`req1` in 1: request; held high until the matching `ack`.
- `we0`/`we1` in 1: 1 = write, 0 = read; sampled with `req`.
- `ind0`/`ind1` in 1: indirect read; ignored on writes.
- `addr0`/`addr1` in `length`: request address.
- `wdata0`/`wdata1` in `width`: write data.
- `ack0`/`ack1` out 1: one-cycle completion pulse.
- `rdata0`/`rdata1` out `width`: read result; valid while `ack` is high; otherwise holds its last value.
- `err` out 1: high with `ack` when a read timed out.
- `busy` out 1: high in every state except IDLE.
- `ramAddr` out `length`, `ramWriteData` out `width`: command fields to the RAM.
- `ramWriteEnable`, `ramReadEnable`, `ramIndirect` out 1: RAM command strobes.
- `ramDataReady` in 1, `ramReadData` in `width`: RAM read response.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If any `req` is high, select a winner and latch its `we`, `ind`, `addr` and `wdata` into command registers. Next state is ISSUE.
  - If neither `req` is high, stay in IDLE.
- **Arbitration:**
  - Only one requester: it wins.
  - Both requesting: the port not served last wins.
  - `last` updates on entry to DONE. It resets to 1, so port 0 wins the first tie.
- **ISSUE:**
  - Drive exactly one of `ramWriteEnable` or `ramReadEnable` for this one cycle. Drive `ramIndirect` = latched `ind` for reads, 0 for writes.
  - A write goes to DONE.
  - A read goes to WAIT with the timeout counter at 0.
- **WAIT:**
  - If `ramDataReady` = 1, capture `ramReadData` into the winner's `rdata` and go to DONE.
  - Otherwise increment the counter. When the counter reaches `timeout`, set `err`, leave `rdata` unchanged, and go to DONE.
- **DONE:**
  - Pulse the winner's `ack`; `err` is valid during this cycle.
  - Go to IDLE. A `req` still high in IDLE is treated as a new request.
- Command registers and `ram*` outputs are registered. All enables are 0 outside ISSUE.
- `ramAddr` and `ramWriteData` hold their last values outside ISSUE.
- Inputs on the losing port are ignored until it is granted. `req` dropped before `ack` is a protocol violation: the latched command still completes and `ack` still pulses.
- This block never drives the RAM's own clear input.

## Timing
- Cycle numbering: `req` is first high in IDLE in cycle 0.
  - Write: RAM enable in cycle 1, `ack` in cycle 2.
  - Read with the RAM answering in the cycle after ISSUE: enable in cycle 1, `dataReady` seen in cycle 2, `ack` in cycle 3.
  - Read timeout: `ack` with `err` in cycle 2 + `timeout` + 1.
- **Throughput:**
  - Back-to-back writes from one port: one every 3 cycles (IDLE/ISSUE/DONE).
  - Back-to-back reads: one every 4 cycles.
- **Reset** (any state, including mid-WAIT):
  - Next state IDLE, counter 0, `last` = 1.
  - `ack0`, `ack1`, `err`, `busy` and all RAM enables = 0.
  - `ramAddr`, `ramWriteData`, `rdata0` and `rdata1` = 0.
  - An in-flight command is dropped without `ack`.
- **Simultaneous events:** a `req` rising in the same cycle as another port's `ack` is served in the next IDLE.

## Structure
- **Package `data_ram_arb_pkg`:** state encoding constants (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the port index constants.
- **Sub-module `rr_arbiter2`:** combinational two-way grant from `req0`, `req1` and `last`, output `grant` (1 bit) plus `any`. This keeps the arbitration policy testable in isolation.
- The counter width is sized by `$clog2(timeout+1)`.

## Test plan
- **Single write:** `req0`=1, `we0`=1, `addr0`=0x10, `wdata0`=0xA5 → `ramWriteEnable` high in cycle 1 only with `ramAddr`=0x10 and `ramWriteData`=0xA5; `ack0` in cycle 2.
- **Direct and indirect read:** RAM model returns `dataReady` one cycle after enable. `req1` read of 0x10 → `ack1` in cycle 3 with `rdata1`=0xA5. Then an indirect read with `ind1`=1 → `ramIndirect`=1 during ISSUE.
- **Contention:** `req0` and `req1` both held continuously → grants alternate 0, 1, 0, 1, and each `ack` lands on its own port.
- **Timeout:** RAM model never raises `dataReady`, `timeout`=15 → `ack` with `err`=1 in cycle 18; `rdata` unchanged.
- **Reset mid-WAIT:** `clr`=1 during WAIT → next cycle in IDLE with all outputs 0, no `ack`. A following tie is granted to port 0.
- **Held `req`:** `req0` held after `ack0` → a second identical command is issued 3 cycles (write) or 4 cycles (read) after the first.
